// File: rtl/mips_run_ctrl_if.sv
// Command handshake bundle for the MIPS run/debug controller.
// Carries cmd_valid/cmd_ready plus the opcode and its 32-bit argument.
interface mips_run_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/debug controller: gates the core clock-enable, takes HALT/RUN/STEP/SET_BP
// over cmd (slave), stops on a PC breakpoint. Ports: clk, rst (sync, low),
// cmd, pc_current in; core_en (comb), halted, bp_hit, cycle_count out.
module mips_run_ctrl #(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    mips_run_ctrl_if.slave     cmd,
    input  logic [31:0]        pc_current,
    output logic               core_en,
    output logic               halted,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   cycle_count
);

    typedef enum logic [1:0] {
        S_HALTED   = 2'b00,
        S_RUNNING  = 2'b01,
        S_STEPPING = 2'b10
    } state_t;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_BP   = 2'b11;

    state_t              r_state;
    logic [STEP_W-1:0]   r_steps_left;
    logic [31:0]         r_bp_addr;
    logic                r_bp_en;
    logic                r_skip;
    logic                r_halted;
    logic                r_bp_hit;
    logic [CNT_W-1:0]    r_cycle_count;

    logic                w_accept;
    logic                w_bp_match;
    logic                w_core_en;
    logic [STEP_W-1:0]   w_step_arg;
    logic [STEP_W-1:0]   w_step_load;

    assign cmd.cmd_ready = (r_state != S_STEPPING);
    assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;

    assign w_step_arg  = cmd.cmd_arg[STEP_W-1:0];
    // STEP 0 behaves as STEP 1 so a step always advances the core.
    assign w_step_load = (w_step_arg == '0) ? STEP_W'(1) : w_step_arg;

    // skip suppresses the match for the first RUNNING cycle so a resume
    // from the breakpoint executes the instruction sitting at bp_addr.
    assign w_bp_match = r_bp_en & ~r_skip
                      & (pc_current == r_bp_addr)
                      & (r_state == S_RUNNING);

    always_comb begin
        w_core_en = 1'b0;
        unique case (r_state)
            S_RUNNING:  w_core_en = ~w_bp_match;
            S_STEPPING: w_core_en = 1'b1;
            default:    w_core_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_HALTED;
            r_steps_left  <= '0;
            r_bp_addr     <= '0;
            r_bp_en       <= 1'b0;
            r_skip        <= 1'b0;
            r_halted      <= 1'b1;
            r_bp_hit      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_bp_hit <= 1'b0;

            if (w_core_en) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end

            // Only reachable outside STEPPING since cmd_ready gates accept.
            if (w_accept && cmd.cmd_op == OP_BP) begin
                if (cmd.cmd_arg[1:0] == 2'b11) begin
                    r_bp_en <= 1'b0;
                end else begin
                    r_bp_addr <= {cmd.cmd_arg[31:2], 2'b00};
                    r_bp_en   <= 1'b1;
                end
            end

            unique case (r_state)
                S_HALTED: begin
                    if (w_accept && cmd.cmd_op == OP_RUN) begin
                        r_state  <= S_RUNNING;
                        r_skip   <= 1'b1;
                        r_halted <= 1'b0;
                    end else if (w_accept && cmd.cmd_op == OP_STEP) begin
                        r_state      <= S_STEPPING;
                        r_steps_left <= w_step_load;
                        r_halted     <= 1'b0;
                    end
                end
                S_RUNNING: begin
                    r_skip <= 1'b0;
                    // A match outranks a simultaneous HALT so it is reported.
                    if (w_bp_match) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                        r_bp_hit <= 1'b1;
                    end else if (w_accept && cmd.cmd_op == OP_HALT) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_STEPPING: begin
                    r_steps_left <= r_steps_left - STEP_W'(1);
                    if (r_steps_left == STEP_W'(1)) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign core_en     = w_core_en;
    assign halted      = r_halted;
    assign bp_hit      = r_bp_hit;
    assign cycle_count = r_cycle_count;

endmodule
